// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter
// Round-robin arbiter that shares one FIFO read port between N_REQ consumers
// in the read clock domain. The winning consumer owns the port for a burst of
// up to BURST_LEN reads. Every returned word is routed back to the consumer
// that issued the read, through a valid/owner pipeline matched to RD_LAT.
//
// Ports:
//   i_clk          read-domain clock, rising edge
//   i_rst          synchronous active-high reset
//   i_req          per-consumer level request
//   o_grant        one-hot owner of the current burst, zero while idle
//   o_burst_done   one-cycle pulse on the owner's bit after its burst closes
//   i_fifo_empty   FIFO empty flag (already accounts for last cycle's read)
//   o_fifo_ren     FIFO read enable
//   i_fifo_rdata   FIFO read data, valid RD_LAT cycles after o_fifo_ren
//   o_rd_data      returned word, registered
//   o_rd_valid     one-hot destination of o_rd_data, zero when no word
module fifo_rd_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int RD_LAT    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_REQ-1:0]  i_req,
    output logic [N_REQ-1:0]  o_grant,
    output logic [N_REQ-1:0]  o_burst_done,
    input  logic              i_fifo_empty,
    output logic              o_fifo_ren,
    input  logic [DATA_W-1:0] i_fifo_rdata,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [N_REQ-1:0]  o_rd_valid
);

    localparam int GID_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             r_state;
    logic [GID_W-1:0]   r_gid;
    logic [GID_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_burst_done;

    logic               r_vld_p [RD_LAT];
    logic [GID_W-1:0]   r_gid_p [RD_LAT];
    logic [DATA_W-1:0]  r_rd_data;
    logic [N_REQ-1:0]   r_rd_valid;

    logic               w_owner_req;
    logic               w_ren;
    logic               w_exit;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [GID_W-1:0]   w_pick;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [GID_W-1:0] g);
        onehot = N_REQ'(1) << g;
    endfunction

    // Round-robin search starting at last+1. The scan runs from the farthest
    // candidate to the nearest so the nearest set bit is written last and wins.
    function automatic logic [GID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [GID_W-1:0] last);
        logic [GID_W-1:0] pick;
        logic [GID_W-1:0] idx_g;
        int               idx;
        pick = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx   = (int'(last) + i) % N_REQ;
            idx_g = GID_W'(idx);
            if (req[idx_g]) pick = idx_g;
        end
        return pick;
    endfunction

    always_comb begin
        w_owner_req = i_req[r_gid];
        w_cnt_nxt   = r_cnt + 1'b1;
        // Read enable is gated by reset so nothing is pulled from the FIFO
        // in a cycle whose pipeline state is about to be thrown away.
        w_ren       = (r_state == ST_BURST) && w_owner_req && !i_fifo_empty &&
                      (r_cnt < CNT_W'(BURST_LEN)) && !i_rst;
        w_exit      = (r_state == ST_BURST) &&
                      (!w_owner_req || i_fifo_empty ||
                       (w_ren && (w_cnt_nxt == CNT_W'(BURST_LEN))));
        w_pick      = rr_pick(i_req, r_last);
    end

    // Arbitration / burst control
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_gid        <= '0;
            r_last       <= GID_W'(N_REQ - 1);
            r_cnt        <= '0;
            r_grant      <= '0;
            r_burst_done <= '0;
        end else begin
            r_burst_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|i_req) begin
                        r_gid   <= w_pick;
                        r_cnt   <= '0;
                        r_grant <= onehot(w_pick);
                        r_state <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (w_ren) r_cnt <= w_cnt_nxt;
                    // Exit always lands in IDLE for at least one cycle, which
                    // is where the done pulse and the next arbitration happen.
                    if (w_exit) begin
                        r_state      <= ST_IDLE;
                        r_last       <= r_gid;
                        r_grant      <= '0;
                        r_burst_done <= onehot(r_gid);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Return pipeline stage p0..p(RD_LAT-1): valid flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < RD_LAT; i++) r_vld_p[i] <= 1'b0;
        end else begin
            r_vld_p[0] <= w_ren;
            for (int i = 1; i < RD_LAT; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
    end

    // Return pipeline stage p0..p(RD_LAT-1): owner tags
    always_ff @(posedge i_clk) begin
        r_gid_p[0] <= r_gid;
        for (int i = 1; i < RD_LAT; i++) r_gid_p[i] <= r_gid_p[i-1];
    end

    // Output stage: FIFO data is valid in the cycle the last tag stage holds
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= r_vld_p[RD_LAT-1] ? onehot(r_gid_p[RD_LAT-1]) : '0;
            if (r_vld_p[RD_LAT-1]) r_rd_data <= i_fifo_rdata;
        end
    end

    assign o_grant      = r_grant;
    assign o_burst_done = r_burst_done;
    assign o_fifo_ren   = w_ren;
    assign o_rd_data    = r_rd_data;
    assign o_rd_valid   = r_rd_valid;

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Round-robin read-port arbiter for the asynchronous FIFO. It sits entirely in the read clock domain and shares the single FIFO read port between `N_REQ` consumers. Each granted consumer receives a bounded burst of up to `BURST_LEN` words. The block drives the FIFO read enable from the FIFO's empty flag and routes each returned word to the consumer that issued the read, using a valid pipeline matched to the FIFO read latency.

## Interface
- `N_REQ`, 4, number of requesters (≥2).
- `DATA_W`, 8, FIFO data width.
- `BURST_LEN`, 4, maximum reads per grant (≥1).
- `RD_LAT`, 2, cycles from `fifo_ren` high to `fifo_rdata` holding that word (≥1).
- `clk`  in  1  read-domain clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-consumer read request, level.
- `grant`  out  N_REQ  one-hot owner of the current burst; all-zero when idle.
- `burst_done`  out  N_REQ  one-cycle pulse on the owner's bit when its burst closes.
- `fifo_empty`  in  1  FIFO empty flag (registered in the FIFO).
- `fifo_ren`  out  1  FIFO read enable.
- `fifo_rdata`  in  DATA_W  FIFO read data.
- `rd_data`  out  DATA_W  returned word, registered.
- `rd_valid`  out  N_REQ  one-hot destination of `rd_data`; all-zero = no word.

## Operation
- States: IDLE, BURST.
  - Registers: `gid` (owner index), `last` (previous owner), `cnt` (reads issued, width clog2(BURST_LEN+1)).
- IDLE:
  - `grant` = 0 and `fifo_ren` = 0.
  - If `|req`, pick the first set bit searching `last+1`, `last+2`, … modulo `N_REQ`.
  - Load `gid`, clear `cnt`, and go to BURST. `grant` is high from the next cycle.
- BURST:
  - `grant[gid]` = 1.
  - `fifo_ren` = `req[gid] & !fifo_empty & (cnt < BURST_LEN)`. This is combinational from state and inputs, at most one read per cycle.
  - `cnt` increments on each `fifo_ren`.
- BURST exit to IDLE, evaluated each cycle (priority order irrelevant; any one exits):
  - `req[gid]` = 0;
  - `fifo_empty` = 1;
  - the cycle in which `fifo_ren` raises `cnt` to `BURST_LEN`.
- On exit:
  - `last` ← `gid`.
  - `burst_done[gid]` pulses in the first IDLE cycle.
  - `grant` drops in that same cycle.
  - Every burst is followed by at least one IDLE cycle, so arbitration never happens in the same cycle as an exit.
- Zero-read bursts are legal: the owner holds the grant, then the FIFO is empty or `req` has dropped. These still pulse `burst_done` and rotate `last`.
- Return path:
  - An `RD_LAT`-stage shift register carries {valid, `gid`} per issued read.
  - At the final stage, `rd_data` ← `fifo_rdata` and `rd_valid` ← onehot(`gid`) if valid, else 0.
  - Words from a closed burst still return after the grant drops or moves to another requester.
- `req` changes while idle, or for non-owners, have no effect until the next arbitration.
- `fifo_empty` must reflect all reads issued up to the previous cycle. The FIFO flag meets this, so the block never reads an empty FIFO.
- Reset (`rst`=1, any cycle, including mid-burst):
  - state = IDLE, `last` = N_REQ-1 (requester 0 wins first), `cnt` = 0.
  - Return pipeline cleared.
  - In-flight words are discarded; the FIFO pointer has already advanced, and this data loss is accepted.

## Timing
- Reset values: `grant`=0, `burst_done`=0, `fifo_ren`=0, `rd_valid`=0, `rd_data`=0.
- Arbitration: `req` high in cycle T (IDLE) → `grant` in T+1 → first possible `fifo_ren` in T+1.
- Read to data: `fifo_ren` in cycle R → `rd_valid`/`rd_data` in cycle R+RD_LAT+1.
- Peak throughput: `BURST_LEN` reads per `BURST_LEN`+1 cycles under continuous demand.
- `burst_done`: exactly one cycle, never together with `grant` on the same bit.

## Test plan
- Reset release with `req`=0001 and the FIFO holding 10 words:
  - `grant`=0001 one cycle after `req`.
  - 4 consecutive `fifo_ren`, then `burst_done`=0001.
  - `rd_valid`=0001 for 4 words arriving RD_LAT+1 cycles after each read, in FIFO order.
- All `req`=1111 and the FIFO continuously non-empty:
  - Grants rotate 0001→0010→0100→1000→0001.
  - 4 reads each, one idle cycle between bursts.
  - Each `rd_valid` matches the issuing requester.
- FIFO holding 2 words, `req`=0100:
  - 2 reads, then `fifo_empty` closes the burst early.
  - `burst_done`=0100, `last`=2; the next `req`=0101 grants requester 0.
- Owner drops `req` after 1 read with BURST_LEN=4:
  - Burst closes with `cnt`=1.
  - The in-flight word is still delivered to that owner after `grant` moves.
- Empty FIFO, `req`=0010:
  - Zero-read burst: `grant` for 1 cycle, `burst_done` pulse, no `fifo_ren`, no `rd_valid`.
- `rst` asserted mid-burst with 2 reads in flight:
  - Next cycle all outputs are 0 and no `rd_valid` ever appears for those reads.
  - The first post-reset grant goes to requester 0.
